// File: rtl/ftdi_echo_engine_pkg.sv
// Shared types for the FTDI echo engine: FSM state encoding and the per-byte
// transform applied on the way back to the host.
package echo_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_STROBE,
      RD_GAP,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD,
      DONE
   } echo_state_t;

   typedef enum logic [1:0] {
      PASS,
      INV,
      INC,
      NSWAP
   } echo_mode_t;

   function automatic logic [7:0] xform(input echo_mode_t m, input logic [7:0] b);
      case (m)
         INV:     xform = ~b;
         INC:     xform = b + 8'd1;
         NSWAP:   xform = {b[3:0], b[7:4]};
         default: xform = b;
      endcase
   endfunction

endpackage

// File: rtl/ftdi_echo_engine_fifo.sv
// Synchronous FIFO between the read and write sides of the echo engine.
// Extra pointer MSB distinguishes full from empty; push when full / pop when empty are ignored.
module echo_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 512
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wp_q, wp_d;
   logic [AW:0]      rp_q, rp_d;
   logic             do_push, do_pop;

   assign empty_o = (wp_q == rp_q);
   assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rp_q[AW-1:0]];

   always_comb begin
      wp_d = wp_q + {{AW{1'b0}}, do_push};
      rp_d = rp_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem_q[wp_q[AW-1:0]] <= din_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

endmodule

// File: rtl/ftdi_echo_engine.sv
// FT245-style loopback: reads bytes over adbus into a FIFO, transforms and echoes them back,
// either a whole packet at a time or cut-through. STREAM_ONLY waives the packet depth check.
module ftdi_echo_engine
   import echo_pkg::*;
#(
   parameter int PKT_BYTES   = 512,
   parameter int FIFO_DEPTH  = 512,
   parameter int RD_PULSE    = 2,
   parameter int WR_PULSE    = 2,
   parameter bit STREAM_ONLY = 1'b0,
   localparam int CW         = $clog2(PKT_BYTES + 1)
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          en_i,
   input  logic          clear_i,
   input  logic          stream_i,
   input  logic [1:0]    mode_i,
   input  logic          rxf_i,
   input  logic          txe_i,
   input  logic [7:0]    adbus_in_i,
   output logic [7:0]    adbus_out_o,
   output logic          adbus_tri_o,
   output logic          ftdi_rd_o,
   output logic          ftdi_wr_o,
   output logic [7:0]    data_in_o,
   output logic          data_valid_o,
   output logic [CW-1:0] rx_ct_o,
   output logic [CW-1:0] tx_ct_o,
   output logic          tx_done_o,
   output logic          busy_o
);

   localparam int PMAX = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
   localparam int CNTW = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam logic [CNTW-1:0] RD_LAST = CNTW'(RD_PULSE - 1);
   localparam logic [CNTW-1:0] WR_LAST = CNTW'(WR_PULSE - 1);
   localparam logic [CW-1:0]   PKT_C   = CW'(PKT_BYTES);
   localparam logic [CW-1:0]   PKT_M1  = CW'(PKT_BYTES - 1);

   generate
      if (!STREAM_ONLY && FIFO_DEPTH < PKT_BYTES) begin : g_chk_depth
         $error("FIFO_DEPTH must be >= PKT_BYTES for packet mode");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_pow2
         $error("FIFO_DEPTH must be a power of 2, at least 2");
      end
      if (RD_PULSE < 1 || WR_PULSE < 1 || PKT_BYTES < 1) begin : g_chk_pulse
         $error("RD_PULSE, WR_PULSE and PKT_BYTES must be >= 1");
      end
   endgenerate

   echo_state_t     state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [CW-1:0]   rx_ct_q, rx_ct_d;
   logic [CW-1:0]   tx_ct_q, tx_ct_d;
   logic [7:0]      data_in_q, data_in_d;
   logic            dv_q, dv_d;
   logic [7:0]      out_q, out_d;
   logic            last_wr_q, last_wr_d;

   logic            push, pop, full, empty;
   logic [7:0]      head, wr_byte;
   logic            can_rd, can_wr;

   echo_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clock_i),
      .rst_i   (reset_i),
      .clr_i   (clear_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (adbus_in_i),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign can_rd  = !rxf_i && !full && (rx_ct_q < PKT_C) && (stream_i || tx_ct_q == '0);
   assign can_wr  = !txe_i && !empty && (stream_i || rx_ct_q == PKT_C);
   assign wr_byte = xform(echo_mode_t'(mode_i), head);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rx_ct_d   = rx_ct_q;
      tx_ct_d   = tx_ct_q;
      data_in_d = data_in_q;
      dv_d      = 1'b0;
      out_d     = out_q;
      last_wr_d = last_wr_q;
      push      = 1'b0;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            // Round robin on contention; last_wr_q starts at 1 so the first grant is a read.
            if (en_i) begin
               if (can_rd && (!can_wr || last_wr_q)) begin
                  state_d   = RD_STROBE;
                  cnt_d     = '0;
                  last_wr_d = 1'b0;
               end else if (can_wr) begin
                  state_d   = WR_SETUP;
                  last_wr_d = 1'b1;
               end
            end
         end
         RD_STROBE: begin
            if (cnt_q == RD_LAST) begin
               push      = 1'b1;
               data_in_d = adbus_in_i;
               dv_d      = 1'b1;
               rx_ct_d   = rx_ct_q + CW'(1);
               state_d   = RD_GAP;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         RD_GAP: state_d = IDLE;
         WR_SETUP: begin
            out_d   = wr_byte;
            cnt_d   = '0;
            state_d = WR_STROBE;
         end
         WR_STROBE: begin
            if (cnt_q == WR_LAST) state_d = WR_HOLD;
            else                  cnt_d   = cnt_q + CNTW'(1);
         end
         WR_HOLD: begin
            pop     = 1'b1;
            tx_ct_d = tx_ct_q + CW'(1);
            state_d = (tx_ct_q == PKT_M1) ? DONE : IDLE;
         end
         DONE: begin
            rx_ct_d = '0;
            tx_ct_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i || clear_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rx_ct_q   <= '0;
         tx_ct_q   <= '0;
         data_in_q <= '0;
         dv_q      <= 1'b0;
         out_q     <= '0;
         last_wr_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rx_ct_q   <= rx_ct_d;
         tx_ct_q   <= tx_ct_d;
         data_in_q <= data_in_d;
         dv_q      <= dv_d;
         out_q     <= out_d;
         last_wr_q <= last_wr_d;
      end
   end

   // Bus controls decode straight from the state register, so clear releases them next cycle.
   assign ftdi_rd_o    = (state_q != RD_STROBE);
   assign ftdi_wr_o    = (state_q != WR_STROBE);
   assign adbus_tri_o  = (state_q == WR_SETUP) || (state_q == WR_STROBE) || (state_q == WR_HOLD);
   assign adbus_out_o  = (state_q == WR_SETUP) ? wr_byte : out_q;
   assign data_in_o    = data_in_q;
   assign data_valid_o = dv_q;
   assign rx_ct_o      = rx_ct_q;
   assign tx_ct_o      = tx_ct_q;
   assign tx_done_o    = (state_q == DONE);
   assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_ftdi_echo_engine.sv
// Directed bench: two engines (packet PKT=4/DEPTH=4, stream PKT=8/DEPTH=2) against a host FTDI model.
module tb_ftdi_echo_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, clear = 1'b0, en = 1'b0;
   logic       stream_a = 1'b0, stream_b = 1'b1;
   logic [1:0] mode = 2'd0;
   logic       txe_w [2] = '{1'b1, 1'b1};
   logic       rxf_r [2] = '{1'b1, 1'b1};
   logic [7:0] ain   [2] = '{8'h00, 8'h00};
   logic [7:0] aout  [2];
   logic       tri_w [2], rd_w [2], wr_w [2], dv_w [2], done_w [2], busy_w [2];
   logic [7:0] data_in_a, data_in_b;
   logic [2:0] rx_ct_a, tx_ct_a;
   logic [3:0] rx_ct_b, tx_ct_b;

   ftdi_echo_engine #(.PKT_BYTES(4), .FIFO_DEPTH(4), .RD_PULSE(2), .WR_PULSE(2)) dut_a (
      .clock_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .stream_i(stream_a),
      .mode_i(mode), .rxf_i(rxf_r[0]), .txe_i(txe_w[0]), .adbus_in_i(ain[0]),
      .adbus_out_o(aout[0]), .adbus_tri_o(tri_w[0]), .ftdi_rd_o(rd_w[0]), .ftdi_wr_o(wr_w[0]),
      .data_in_o(data_in_a), .data_valid_o(dv_w[0]), .rx_ct_o(rx_ct_a), .tx_ct_o(tx_ct_a),
      .tx_done_o(done_w[0]), .busy_o(busy_w[0]));

   ftdi_echo_engine #(.PKT_BYTES(8), .FIFO_DEPTH(2), .RD_PULSE(1), .WR_PULSE(3),
                      .STREAM_ONLY(1'b1)) dut_b (
      .clock_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .stream_i(stream_b),
      .mode_i(mode), .rxf_i(rxf_r[1]), .txe_i(txe_w[1]), .adbus_in_i(ain[1]),
      .adbus_out_o(aout[1]), .adbus_tri_o(tri_w[1]), .ftdi_rd_o(rd_w[1]), .ftdi_wr_o(wr_w[1]),
      .data_in_o(data_in_b), .data_valid_o(dv_w[1]), .rx_ct_o(rx_ct_b), .tx_ct_o(tx_ct_b),
      .tx_done_o(done_w[1]), .busy_o(busy_w[1]));

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // host FTDI model state
   logic [7:0] hdat [2][32];
   logic [7:0] wdat [2][32];
   int hn [2] = '{0, 0}, ha [2] = '{0, 0}, nr [2] = '{0, 0}, nw [2] = '{0, 0};
   int rdlow [2] = '{0, 0}, wrlow [2] = '{0, 0}, hold [2] = '{0, 0};
   int rdmin [2] = '{99, 99}, rdmax [2] = '{0, 0}, wrmin [2] = '{99, 99}, wrmax [2] = '{0, 0};
   int ndv [2] = '{0, 0}, ndone [2] = '{0, 0}, nr_first_w [2] = '{-1, -1}, nev [2] = '{0, 0};
   bit ev [2][64];
   bit toggle [2] = '{1'b0, 1'b0};
   bit prev_rd [2] = '{1'b1, 1'b1}, prev_wr [2] = '{1'b1, 1'b1}, prev_rxf [2] = '{1'b1, 1'b1};
   logic [7:0] wbyte [2];
   int viol = 0;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rd_w[d]) rdlow[d]++;
         if (!rd_w[d] && prev_rd[d] && prev_rxf[d]) viol++;
         if (!rd_w[d] && tri_w[d]) viol++;
         if (rd_w[d] && !prev_rd[d]) begin
            if (rdlow[d] < rdmin[d]) rdmin[d] = rdlow[d];
            if (rdlow[d] > rdmax[d]) rdmax[d] = rdlow[d];
            ha[d]++; nr[d]++;
            ev[d][nev[d] % 64] = 1'b0; nev[d]++;
            hold[d] = toggle[d] ? 3 : 0;
            rdlow[d] = 0;
         end
         if (!wr_w[d]) begin
            wrlow[d]++;
            wbyte[d] = aout[d];
         end
         if (wr_w[d] && !prev_wr[d]) begin
            // a write completes only if data is still driven after the strobe rises
            if (tri_w[d]) begin
               if (wrlow[d] < wrmin[d]) wrmin[d] = wrlow[d];
               if (wrlow[d] > wrmax[d]) wrmax[d] = wrlow[d];
               if (nw[d] == 0) nr_first_w[d] = nr[d];
               wdat[d][nw[d] % 32] = wbyte[d]; nw[d]++;
               ev[d][nev[d] % 64] = 1'b1; nev[d]++;
            end
            wrlow[d] = 0;
         end
         if (dv_w[d]) ndv[d]++;
         if (done_w[d]) ndone[d]++;
         prev_rd[d] = rd_w[d];
         prev_wr[d] = wr_w[d];
         if (hold[d] > 0) hold[d]--;
         ain[d]   = hdat[d][ha[d] % 32];
         rxf_r[d] = !((ha[d] < hn[d]) && (hold[d] == 0));
         prev_rxf[d] = rxf_r[d];
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic push_host(input int d, input logic [7:0] b);
      hdat[d][hn[d] % 32] = b;
      hn[d]++;
   endtask

   task automatic wait_nw(input int d, input int target, input string tag);
      int k = 0;
      while (nw[d] < target && k < 600) begin tick; k++; end
      chk(tag, nw[d], target);
      repeat (3) tick;
   endtask

   task automatic chk_writes(input string tag, input int d, input int base, input logic [31:0] exp4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_b%0d", tag, i), wdat[d][base + i], exp4[31 - 8*i -: 8]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int dv0;
      logic [15:0] order;

      repeat (3) tick;
      reset = 1'b0;
      tick;
      chk("rst_rd", rd_w[0], 1'b1);
      chk("rst_wr", wr_w[0], 1'b1);
      chk("rst_tri", tri_w[0], 1'b0);
      chk("rst_out", aout[0], 8'h00);
      chk("rst_din", data_in_a, 8'h00);
      chk("rst_dv", dv_w[0], 1'b0);
      chk("rst_rx", rx_ct_a, 3'd0);
      chk("rst_tx", tx_ct_a, 3'd0);
      chk("rst_done", done_w[0], 1'b0);
      chk("rst_busy", busy_w[0], 1'b0);
      chk("rst_busy_b", busy_w[1], 1'b0);

      // 1: packet echo, pass-through
      push_host(0, 8'h11); push_host(0, 8'h22); push_host(0, 8'h33); push_host(0, 8'h44);
      txe_w[0] = 1'b0;
      en = 1'b1;
      wait_nw(0, 4, "t1_nw");
      chk_writes("t1", 0, 0, 32'h11223344);
      chk("t1_reads", nr[0], 4);
      chk("t1_rd_before_wr", nr_first_w[0], 4);
      chk("t1_done", ndone[0], 1);
      chk("t1_rx", rx_ct_a, 3'd0);
      chk("t1_tx", tx_ct_a, 3'd0);
      chk("t1_din", data_in_a, 8'h44);
      chk("t1_dv", ndv[0], 4);

      // 2: transforms, including 0xFF+1 wrap
      mode = 2'b01;
      push_host(0, 8'h00); push_host(0, 8'hFF); push_host(0, 8'h00); push_host(0, 8'hFF);
      wait_nw(0, 8, "t2_inv_nw");
      chk_writes("t2_inv", 0, 4, 32'hFF00FF00);
      mode = 2'b10;
      push_host(0, 8'h00); push_host(0, 8'hFF); push_host(0, 8'h00); push_host(0, 8'hFF);
      wait_nw(0, 12, "t2_inc_nw");
      chk_writes("t2_inc", 0, 8, 32'h01000100);
      mode = 2'b11;
      push_host(0, 8'h12); push_host(0, 8'hA5); push_host(0, 8'h0F); push_host(0, 8'hF0);
      wait_nw(0, 16, "t2_swap_nw");
      chk_writes("t2_swap", 0, 12, 32'h215AF00F);
      chk("t2_done", ndone[0], 4);

      // 5: en drops mid-read
      mode = 2'b00;
      push_host(0, 8'h5A); push_host(0, 8'h01); push_host(0, 8'h02); push_host(0, 8'h03);
      k = 0;
      while (rd_w[0] && k < 50) begin tick; k++; end
      chk("t5_rd_seen", rd_w[0], 1'b0);
      dv0 = ndv[0];
      en = 1'b0;
      repeat (20) tick;
      chk("t5_reads", nr[0], 17);
      chk("t5_dv", ndv[0], dv0 + 1);
      chk("t5_rx", rx_ct_a, 3'd1);
      chk("t5_din", data_in_a, 8'h5A);
      chk("t5_busy", busy_w[0], 1'b0);
      en = 1'b1;
      wait_nw(0, 20, "t5_nw");
      chk_writes("t5", 0, 16, 32'h5A010203);

      // 4: clear during a write strobe
      push_host(0, 8'hAA); push_host(0, 8'hBB); push_host(0, 8'hCC); push_host(0, 8'hDD);
      k = 0;
      while (wr_w[0] && k < 100) begin tick; k++; end
      chk("t4_wr_seen", wr_w[0], 1'b0);
      clear = 1'b1;
      tick;
      chk("t4_wr", wr_w[0], 1'b1);
      chk("t4_tri", tri_w[0], 1'b0);
      chk("t4_rx", rx_ct_a, 3'd0);
      chk("t4_tx", tx_ct_a, 3'd0);
      chk("t4_busy", busy_w[0], 1'b0);
      chk("t4_din", data_in_a, 8'h00);
      clear = 1'b0;
      chk("t4_no_write", nw[0], 20);
      push_host(0, 8'h66); push_host(0, 8'h77); push_host(0, 8'h88); push_host(0, 8'h99);
      wait_nw(0, 24, "t4_nw");
      chk_writes("t4", 0, 20, 32'h66778899);

      // 3: stream mode, FIFO depth 2, host not accepting
      txe_w[1] = 1'b1;
      for (int i = 1; i <= 8; i++) push_host(1, 8'(i));
      repeat (30) tick;
      chk("t3_reads", nr[1], 2);
      chk("t3_rd_idle", rd_w[1], 1'b1);
      chk("t3_rx", rx_ct_b, 4'd2);
      chk("t3_nw0", nw[1], 0);
      txe_w[1] = 1'b0;
      wait_nw(1, 8, "t3_nw");
      order = '0;
      for (int i = 0; i < 16; i++) order[i] = ev[1][i];
      chk("t3_order", order, 16'hD554);
      chk_writes("t3_lo", 1, 0, 32'h01020304);
      chk_writes("t3_hi", 1, 4, 32'h05060708);
      chk("t3_done", ndone[1], 1);

      // 6: rxf gaps between bytes, nibble swap, strobe widths
      toggle[1] = 1'b1;
      mode = 2'b11;
      for (int i = 0; i < 8; i++) push_host(1, 8'hA0 + 8'(i));
      wait_nw(1, 16, "t6_nw");
      chk_writes("t6_lo", 1, 8, 32'h0A1A2A3A);
      chk_writes("t6_hi", 1, 12, 32'h4A5A6A7A);
      chk("t6_done", ndone[1], 2);
      chk("t6_rx", rx_ct_b, 4'd0);
      chk("t6_tx", tx_ct_b, 4'd0);
      chk("t6_din", data_in_b, 8'hA7);
      chk("t6_viol", viol, 0);
      chk("w_rdmin_a", rdmin[0], 2);
      chk("w_rdmax_a", rdmax[0], 2);
      chk("w_wrmin_a", wrmin[0], 2);
      chk("w_wrmax_a", wrmax[0], 2);
      chk("w_rdmin_b", rdmin[1], 1);
      chk("w_rdmax_b", rdmax[1], 1);
      chk("w_wrmin_b", wrmin[1], 3);
      chk("w_wrmax_b", wrmax[1], 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
